load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit between the CPU pipeline and the byte-addressed data memory (`ram`). Accepts one load or store per valid/ready handshake, decodes RISC-V funct3, splits misaligned and half-word-store accesses into sequential byte beats, and returns a correctly sign- or zero-extended 32-bit load result with a one-cycle response pulse.

## Interface
Parameters
- `ADDRESS_WIDTH`, 32: byte address width; also the RAM address width.
- `DATA_WIDTH`, 32: data width. Only 32 is supported.
- `ALLOW_MISALIGNED`, 1: 1 splits misaligned accesses into byte beats; 0 rejects them with `resp_err`.

Ports
- `clk`  in  1  single clock, all state on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `req_addr`  in  ADDRESS_WIDTH  byte address.
- `req_wdata`  in  DATA_WIDTH  store data, LSB-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- `resp_err`  out  1  illegal funct3 or rejected misalignment; valid with `resp_valid`.
- `mem_we`  out  1  RAM write enable.
- `mem_type`  out  2  RAM dataType: 00 word, 01 byte, 10 half.
- `mem_addr`  out  ADDRESS_WIDTH  RAM address.
- `mem_wd`  out  DATA_WIDTH  RAM write data.
- `mem_rd`  in  DATA_WIDTH  RAM asynchronous read data.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, latch we, funct3, addr, wdata. Clear beat counter and assembly register.
  - Illegal funct3 (load 011/110/111; store ≥011) → DONE, error set, no memory access.
  - Misaligned with `ALLOW_MISALIGNED`=0 → DONE, error set.
  - Otherwise → ACCESS.
- Misalignment rules: half is misaligned if addr[0]=1; word is misaligned if addr[1:0]≠00.
- Beat count:
  - Aligned LW, SW, LB, LBU, SB, aligned LH, LHU: 1 beat.
  - Misaligned half: 2 beats.
  - Misaligned word: 4 beats.
  - SH: always 2 beats. The RAM write path supports word and byte only.
- ACCESS, single beat:
  - `mem_addr` = addr.
  - `mem_type` = 00 word, 01 byte, 10 half.
  - Stores: `mem_wd` = wdata.
  - Loads: capture `mem_rd` at the end of the cycle.
- ACCESS, split beat k:
  - `mem_type` = 01.
  - `mem_addr` = addr + k, modulo 2^ADDRESS_WIDTH; 0xFFFFFFFF+1 wraps to 0.
  - Stores: `mem_wd` = wdata >> 8k.
  - Loads: capture `mem_rd[7:0]` into byte lane k.
- Stores drive `mem_we`=1 in every ACCESS cycle.
- The counter increments each beat. After the last beat the FSM goes to DONE.
- Extension is done here from the raw low bits; RAM-side extension is ignored.
  - LB: sign-extend bit 7. LBU: zero-extend byte.
  - LH: sign-extend bit 15. LHU: zero-extend half.
  - LW: pass all 32 bits.
- DONE:
  - `resp_valid`=1 for exactly one cycle, with `resp_rdata` and `resp_err`.
  - `req_ready`=0. Next state is IDLE.
- `mem_we`=0 in IDLE and DONE. `mem_addr`, `mem_wd` and `mem_type` are don't-care when not in ACCESS; they are driven 0.

## Timing
- Reset values: state IDLE; `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
- `req_ready`=0 and `mem_we`=0 while `rst` is high; `mem_we` is gated combinationally by `!rst`.
- `req_ready`=1 in the first cycle after `rst` falls.
- Request accepted at edge E0:
  - ACCESS occupies cycles 1..N.
  - DONE (`resp_valid` high) is in cycle N+1.
  - Next accept is possible at the end of cycle N+2.
- Error requests: `resp_valid` is high in cycle 1.
- RAM write commits at the posedge ending each ACCESS store cycle. Load data is sampled at the same edge (combinational RAM read).
- `rst` during ACCESS or DONE: FSM goes to IDLE at that edge.
  - The in-flight beat's write is suppressed; remaining beats are never issued.
  - No `resp_valid` for the aborted request.
- `req_valid` outside IDLE is ignored; the requester must hold the request until `req_ready`.

## Test plan
- SW 0x1000 ← 0xDEADBEEF → one beat with `mem_we`=1, `mem_type`=00, `mem_addr`=0x1000; `resp_valid` in cycle 2, `resp_rdata`=0. Then LW 0x1000 → 0xDEADBEEF.
- SB 0x1001 ← 0x00000080. LB 0x1001 → 0xFFFFFF80. LBU 0x1001 → 0x00000080.
- SH 0x1002 ← 0x1234ABCD → two byte beats: 0x1002←0xCD, 0x1003←0xAB. LHU 0x1002 → 0x0000ABCD; LH 0x1002 → 0xFFFFABCD.
- After SW 0x1000 ← 0x11223344 and SW 0x1004 ← 0x55667788: LW 0x1001 → 4 byte beats at addresses 0x1001..0x1004, `resp_valid` in cycle 5, data 0x88112233.
- Load funct3=011 → `resp_err`=1 in cycle 1, no ACCESS cycle, `mem_we` never high. With `ALLOW_MISALIGNED`=0, LW 0x1002 → `resp_err`=1.
- Misaligned SW 0x2001 ← 0xAABBCCDD, `rst` high during beat 2 → only 0x2001=0xDD written, 0x2002..0x2004 unchanged, no `resp_valid`, `req_ready`=1 the cycle after `rst` falls.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store unit
// Splits misaligned and half-word-store accesses into byte beats and extends load data locally.
module load_store_unit #(
  parameter int ADDRESS_WIDTH    = 32,
  parameter int DATA_WIDTH       = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err,
  output logic                     mem_we,
  output logic [1:0]               mem_type,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  input  logic [DATA_WIDTH-1:0]    mem_rd
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                   state_q;
  logic                     we_q;
  logic [2:0]               f3_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [1:0]               beat_q;
  logic [1:0]               last_q;
  logic [DATA_WIDTH-1:0]    asm_q;
  logic                     resp_valid_q;
  logic [DATA_WIDTH-1:0]    resp_rdata_q;
  logic                     resp_err_q;

  logic                     req_illegal;
  logic                     req_misaligned;
  logic [1:0]               req_last;
  logic                     split;
  logic [4:0]               shamt;
  logic [DATA_WIDTH-1:0]    asm_d;
  logic [DATA_WIDTH-1:0]    load_result;

  // Any multi-beat access runs as byte beats; the RAM write path has no half mode.
  always_comb begin
    req_illegal    = req_we ? (req_funct3 > 3'b010)
                            : ((req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110));
    req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_last = 2'd0;
    if ((req_funct3[1:0] == 2'b10) && req_misaligned)
      req_last = 2'd3;
    else if ((req_funct3[1:0] == 2'b01) && (req_misaligned || req_we))
      req_last = 2'd1;
  end

  assign split = (last_q != 2'd0);
  assign shamt = {beat_q, 3'b000};

  always_comb begin
    asm_d = split ? (asm_q | (DATA_WIDTH'(mem_rd[7:0]) << shamt)) : mem_rd;
    case (f3_q)
      3'b000:  load_result = {{(DATA_WIDTH-8){asm_d[7]}}, asm_d[7:0]};
      3'b100:  load_result = {{(DATA_WIDTH-8){1'b0}}, asm_d[7:0]};
      3'b001:  load_result = {{(DATA_WIDTH-16){asm_d[15]}}, asm_d[15:0]};
      3'b101:  load_result = {{(DATA_WIDTH-16){1'b0}}, asm_d[15:0]};
      default: load_result = asm_d;
    endcase
  end

  always_comb begin
    mem_we   = (state_q == ACCESS) && we_q && !rst;
    mem_type = 2'b00;
    mem_addr = '0;
    mem_wd   = '0;
    if (state_q == ACCESS) begin
      mem_addr = addr_q + ADDRESS_WIDTH'(beat_q);
      mem_wd   = wdata_q >> shamt;
      if (split)
        mem_type = 2'b01;
      else begin
        case (f3_q[1:0])
          2'b00:   mem_type = 2'b01;
          2'b01:   mem_type = 2'b10;
          default: mem_type = 2'b00;
        endcase
      end
    end
  end

  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      beat_q       <= 2'd0;
      last_q       <= 2'd0;
      asm_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          resp_valid_q <= 1'b0;
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            beat_q  <= 2'd0;
            last_q  <= req_last;
            asm_q   <= '0;
            if (req_illegal || (req_misaligned && !ALLOW_MISALIGNED)) begin
              state_q      <= DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              state_q <= ACCESS;
            end
          end
        end
        ACCESS: begin
          beat_q <= beat_q + 2'd1;
          asm_q  <= asm_d;
          if (beat_q == last_q) begin
            state_q      <= DONE;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= we_q ? '0 : load_result;
          end
        end
        default: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized bench for load_store_unit against a byte-array model
module tb_load_store_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        tb_init;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wd, mem_rd;
  logic [1:0]  mem_type;

  logic        req_valid2, req_we2;
  logic [2:0]  req_funct32;
  logic [31:0] req_addr2, req_wdata2;
  logic        req_ready2, resp_valid2, resp_err2, mem_we2;
  logic [31:0] resp_rdata2, mem_addr2, mem_wd2;
  logic [31:0] mem_rd2;
  logic [1:0]  mem_type2;

  load_store_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_type(mem_type), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  load_store_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .ALLOW_MISALIGNED(1'b0)) dut_strict (
    .clk(clk), .rst(rst),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2), .req_funct3(req_funct32),
    .req_addr(req_addr2), .req_wdata(req_wdata2),
    .resp_valid(resp_valid2), .resp_rdata(resp_rdata2), .resp_err(resp_err2),
    .mem_we(mem_we2), .mem_type(mem_type2), .mem_addr(mem_addr2), .mem_wd(mem_wd2), .mem_rd(mem_rd2)
  );

  // 4 KiB RAM aliased on the low 12 address bits; sub-word reads sign-extend so the unit must ignore them.
  logic [7:0]  ram     [0:4095];
  logic [7:0]  ref_mem [0:4095];
  logic [11:0] a0, a1, a2, a3;
  assign a0 = mem_addr[11:0];
  assign a1 = a0 + 12'd1;
  assign a2 = a0 + 12'd2;
  assign a3 = a0 + 12'd3;
  assign mem_rd = (mem_type == 2'b01) ? {{24{ram[a0][7]}}, ram[a0]} :
                  (mem_type == 2'b10) ? {{16{ram[a1][7]}}, ram[a1], ram[a0]} :
                                        {ram[a3], ram[a2], ram[a1], ram[a0]};

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'(i * 37 + 5);
    end else if (mem_we) begin
      ram[a0] <= mem_wd[7:0];
      if (mem_type != 2'b01) ram[a1] <= mem_wd[15:8];
      if (mem_type == 2'b00) begin
        ram[a2] <= mem_wd[23:16];
        ram[a3] <= mem_wd[31:24];
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    int          sz;
    logic [31:0] v;
    sz = size_of(f3);
    v  = 32'h0;
    for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[12'(addr + 32'(i))]) << (8 * i));
    if (!f3[2] && sz == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (!f3[2] && sz == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    int          sz, beats, lat_exp, k;
    bit          ill, mis, seen;
    logic [31:0] exp_rd, got_rd;
    logic        got_err;
    logic [31:0] b_addr[$];
    logic [31:0] b_wd[$];
    logic [1:0]  b_type[$];
    logic        b_we[$];
    sz      = size_of(f3);
    ill     = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    mis     = (addr % 32'(sz)) != 32'h0;
    beats   = (sz == 1) ? 1 : (we && sz == 2) ? 2 : mis ? sz : 1;
    lat_exp = ill ? 1 : beats + 1;
    exp_rd  = (we || ill) ? 32'h0 : model_load(f3, addr);
    got_rd  = 32'h0;
    got_err = 1'b0;
    check("ready_idle", 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    seen = 1'b0;
    k    = 1;
    while (!seen && k <= 12) begin
      if (resp_valid) begin
        seen    = 1'b1;
        got_rd  = resp_rdata;
        got_err = resp_err;
      end else begin
        b_addr.push_back(mem_addr);
        b_type.push_back(mem_type);
        b_we.push_back(mem_we);
        b_wd.push_back(mem_wd);
        @(negedge clk);
        k++;
      end
    end
    check("latency", seen ? 32'(k) : 32'h0, 32'(lat_exp));
    check("rdata", got_rd, exp_rd);
    check("err", 32'(got_err), 32'(ill));
    check("beats", 32'(b_addr.size()), ill ? 32'h0 : 32'(beats));
    for (int i = 0; i < b_addr.size() && i < beats && !ill; i++) begin
      check("beat_addr", b_addr[i], addr + 32'(i));
      check("beat_type", 32'(b_type[i]), (beats > 1) ? 32'h1 : (sz == 1) ? 32'h1 : (sz == 2) ? 32'h2 : 32'h0);
      check("beat_we", 32'(b_we[i]), 32'(we));
      if (we) check("beat_wd", b_wd[i], (beats > 1) ? (wdata >> (8 * i)) : wdata);
    end
    if (we && !ill)
      for (int i = 0; i < sz; i++) ref_mem[12'(addr + 32'(i))] = wdata[8*i +: 8];
    @(negedge clk);
    check("resp_pulse", 32'(resp_valid), 32'h0);
  endtask

  task automatic do_op_strict(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic exp_err);
    req_valid2 = 1'b1; req_we2 = we; req_funct32 = f3; req_addr2 = addr; req_wdata2 = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    req_valid2 = 1'b0;
    if (!exp_err) begin
      check("strict_access_we", 32'(mem_we2), 32'(we));
      @(negedge clk);
    end
    check("strict_valid", 32'(resp_valid2), 32'h1);
    check("strict_err", 32'(resp_err2), 32'(exp_err));
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] addr;
    int          bad;
    bit          saw_resp;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'(i * 37 + 5);
    rst = 1'b1; tb_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_valid2 = 1'b0; req_we2 = 1'b0; req_funct32 = 3'b0; req_addr2 = 32'h0; req_wdata2 = 32'h0;
    mem_rd2 = 32'h0;
    repeat (3) @(negedge clk);
    tb_init = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", 32'(resp_err), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(req_ready), 32'h1);

    do_op(1'b1, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF);
    do_op(1'b0, 3'b010, 32'h0000_1000, 32'h0);
    do_op(1'b1, 3'b000, 32'h0000_1001, 32'h0000_0080);
    do_op(1'b0, 3'b000, 32'h0000_1001, 32'h0);
    do_op(1'b0, 3'b100, 32'h0000_1001, 32'h0);
    do_op(1'b1, 3'b001, 32'h0000_1002, 32'h1234_ABCD);
    do_op(1'b0, 3'b101, 32'h0000_1002, 32'h0);
    do_op(1'b0, 3'b001, 32'h0000_1002, 32'h0);
    do_op(1'b1, 3'b010, 32'h0000_1000, 32'h1122_3344);
    do_op(1'b1, 3'b010, 32'h0000_1004, 32'h5566_7788);
    do_op(1'b0, 3'b010, 32'h0000_1001, 32'h0);
    check("lw_misaligned_value", model_load(3'b010, 32'h0000_1001), 32'h8811_2233);
    do_op(1'b0, 3'b011, 32'h0000_1000, 32'h0);
    do_op(1'b1, 3'b011, 32'h0000_1000, 32'h0);
    do_op(1'b0, 3'b101, 32'h0000_1003, 32'h0);
    do_op(1'b1, 3'b010, 32'hFFFF_FFFE, 32'hCAFE_F00D);
    do_op(1'b0, 3'b010, 32'hFFFF_FFFF, 32'h0);

    do_op_strict(1'b0, 3'b010, 32'h0000_1002, 1'b1);
    do_op_strict(1'b0, 3'b001, 32'h0000_1003, 1'b1);
    do_op_strict(1'b1, 3'b010, 32'h0000_1000, 1'b0);

    // Abort a misaligned store with reset during its second beat.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0000_2001; req_wdata = 32'hAABB_CCDD;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_beat0_addr", mem_addr, 32'h0000_2001);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_we_gated", 32'(mem_we), 32'h0);
    check("abort_ready_low", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_ready", 32'(req_ready), 32'h1);
    ref_mem[12'h001] = 8'hDD;
    saw_resp = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) saw_resp = 1'b1;
    end
    check("abort_no_resp", 32'(saw_resp), 32'h0);
    for (int i = 1; i <= 4; i++) check("abort_bytes", 32'(ram[i]), 32'(ref_mem[i]));

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 3))
        0:       addr = 32'h0000_1000 + 32'($urandom_range(0, 63));
        1:       addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        2:       addr = $urandom;
        default: addr = 32'h0000_2000 + 32'($urandom_range(0, 15));
      endcase
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, $urandom);
    end

    bad = 0;
    for (int i = 0; i < 4096; i++) if (ram[i] !== ref_mem[i]) bad++;
    check("mem_image", 32'(bad), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
